// File: rtl/matrix_bank.sv
// Multi-slot matrix store: row-major write and read streams with per-slot dims.
// Optional MATRIX_BANK_ERR_EN adds an err pulse for illegal commands.
module matrix_bank #(
    parameter int DATA_W  = 32,
    parameter int MAX_DIM = 5,
    parameter int SLOTS   = 8,
    localparam int DIM_W  = $clog2(MAX_DIM + 1),
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [SLOT_W-1:0] cmd_slot,
    input  logic [DIM_W-1:0]  cmd_rows,
    input  logic [DIM_W-1:0]  cmd_cols,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [SLOTS-1:0]  slot_valid,
    input  logic [SLOT_W-1:0] meta_slot,
    output logic [DIM_W-1:0]  meta_rows,
    output logic [DIM_W-1:0]  meta_cols
`ifdef MATRIX_BANK_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int AREA  = MAX_DIM * MAX_DIM;
    localparam int DEPTH = SLOTS * AREA;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int K_W   = $clog2(AREA + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DIM_W-1:0]  rows_q [SLOTS];
    logic [DIM_W-1:0]  cols_q [SLOTS];
    logic [SLOT_W-1:0] cur_slot;
    logic [K_W-1:0]    cur_n;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    f;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              slot_ok, wr_legal, rd_legal;
    logic              cmd_fire, wr_fire, rd_fire, load;
    logic              wr_end;

    assign wr_addr = AW'(32'(cur_slot) * AREA + 32'(k));
    assign rd_addr = AW'(32'(cur_slot) * AREA + 32'(f));

    assign meta_rows = (32'(meta_slot) < SLOTS) ? rows_q[meta_slot] : '0;
    assign meta_cols = (32'(meta_slot) < SLOTS) ? cols_q[meta_slot] : '0;

    always_comb begin
        state_nx  = state;
        cmd_ready = (state == IDLE);
        wr_ready  = (state == WRITE);
        busy      = (state != IDLE);
        slot_ok   = 32'(cmd_slot) < SLOTS;
        wr_legal  = slot_ok
                    && cmd_rows != '0 && 32'(cmd_rows) <= MAX_DIM
                    && cmd_cols != '0 && 32'(cmd_cols) <= MAX_DIM;
        rd_legal  = slot_ok && slot_valid[cmd_slot];
        cmd_fire  = cmd_valid && cmd_ready;
        wr_fire   = wr_valid && wr_ready;
        rd_fire   = rd_valid && rd_ready;
        wr_end    = wr_fire && (k == cur_n - K_W'(1));
        // Refill the output register whenever it is empty or being drained
        load      = (state == READ) && (!rd_valid || rd_ready) && (f != cur_n);
        unique case (state)
            IDLE: begin
                if (cmd_fire && !cmd_op && wr_legal)
                    state_nx = WRITE;
                else if (cmd_fire && cmd_op && rd_legal)
                    state_nx = READ;
            end
            WRITE: if (wr_end) state_nx = IDLE;
            READ:  if (rd_fire && rd_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef MATRIX_BANK_ERR_EN
    logic illegal;
    assign illegal = cmd_fire && !(cmd_op ? rd_legal : wr_legal);

    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else        err <= illegal;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_valid <= '0;
            cur_slot   <= '0;
            cur_n      <= '0;
            k          <= '0;
            f          <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                rows_q[i] <= '0;
                cols_q[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (cmd_fire && !cmd_op && wr_legal) begin
                rows_q[cmd_slot]     <= cmd_rows;
                cols_q[cmd_slot]     <= cmd_cols;
                slot_valid[cmd_slot] <= 1'b0;
                cur_slot             <= cmd_slot;
                cur_n                <= K_W'(32'(cmd_rows) * 32'(cmd_cols));
                k                    <= '0;
            end
            if (cmd_fire && cmd_op && rd_legal) begin
                cur_slot <= cmd_slot;
                cur_n    <= K_W'(32'(rows_q[cmd_slot]) * 32'(cols_q[cmd_slot]));
                f        <= '0;
            end
            if (wr_fire) begin
                k <= k + K_W'(1);
                if (wr_end)
                    slot_valid[cur_slot] <= 1'b1;
            end
            if (load) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[rd_addr];
                rd_last  <= (f == cur_n - K_W'(1));
                f        <= f + K_W'(1);
            end else if (rd_fire) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

endmodule
